multiphase_driver: RTL and testbench

//  N-channel complementary gate driver: one shared period counter, per-channel duty and phase, programmable dead time.

---
 rtl/multiphase_driver_pkg.sv | 41 ++++
 rtl/multiphase_driver_deadtime.sv | 78 +++++++
 rtl/multiphase_driver.sv | 161 ++++++++++++++++
 tb/tb_multiphase_driver.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/multiphase_driver_pkg.sv
// Shared types and constants for the multiphase complementary gate driver.
// The config struct is sized by the MDRV_* constants, which are also the module parameter defaults.
package multiphase_driver_pkg;

  localparam int unsigned MDRV_N_CH       = 4;
  localparam int unsigned MDRV_PER_BITS   = 16;
  localparam int unsigned MDRV_DT_BITS    = 8;
  localparam int unsigned MDRV_BURST_BITS = 16;
  localparam int unsigned MIN_PERIOD      = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StBurst,
    StStopping
  } state_t;

  typedef struct packed {
    logic [MDRV_PER_BITS-1:0]                period;
    logic [MDRV_N_CH-1:0][MDRV_PER_BITS-1:0] duty;
    logic [MDRV_N_CH-1:0][MDRV_PER_BITS-1:0] phase;
    logic [MDRV_DT_BITS-1:0]                 dead;
    logic [MDRV_BURST_BITS-1:0]              burst_len;
  } mdrv_cfg_t;

  // Clamp period to the minimum and keep every phase inside the period so pos never underflows.
  function automatic mdrv_cfg_t sanitize_cfg(input mdrv_cfg_t c);
    mdrv_cfg_t r;
    r = c;
    if (c.period < MDRV_PER_BITS'(MIN_PERIOD)) begin
      r.period = MDRV_PER_BITS'(MIN_PERIOD);
    end
    for (int i = 0; i < int'(MDRV_N_CH); i++) begin
      if (c.phase[i] >= r.period) begin
        r.phase[i] = r.period - MDRV_PER_BITS'(1);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multiphase_driver_deadtime.sv
// Per-channel dead-time inserter: registered complementary p/n pair derived from a raw PWM level.
// Any raw edge drops both outputs; they follow raw again once the dead count expires.
module drv_deadtime
  import multiphase_driver_pkg::*;
#(
  parameter int unsigned DT_BITS = MDRV_DT_BITS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               raw,
  input  logic [DT_BITS-1:0] dead,
  input  logic               enable,
  output logic               p,
  output logic               n,
  output logic [DT_BITS-1:0] dead_cnt
);

  logic               raw_q;
  logic               p_q, p_d;
  logic               n_q, n_d;
  logic [DT_BITS-1:0] cnt_q, cnt_d;
  logic               raw_edge;

  assign raw_edge = raw ^ raw_q;

  always_comb begin
    p_d   = p_q;
    n_d   = n_q;
    cnt_d = cnt_q;
    if (!enable) begin
      p_d   = 1'b0;
      n_d   = 1'b0;
      cnt_d = '0;
    end else if (raw_edge) begin
      if (dead == '0) begin
        p_d   = raw;
        n_d   = ~raw;
        cnt_d = '0;
      end else begin
        p_d   = 1'b0;
        n_d   = 1'b0;
        cnt_d = dead;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - DT_BITS'(1);
      if (cnt_q == DT_BITS'(1)) begin
        p_d = raw;
        n_d = ~raw;
      end else begin
        p_d = 1'b0;
        n_d = 1'b0;
      end
    end else begin
      p_d = raw;
      n_d = ~raw;
    end
  end

  // raw_q tracks raw even while disabled so a run starts without a spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q <= 1'b0;
      p_q   <= 1'b0;
      n_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      raw_q <= raw;
      p_q   <= p_d;
      n_q   <= n_d;
      cnt_q <= cnt_d;
    end
  end

  assign p        = p_q;
  assign n        = n_q;
  assign dead_cnt = cnt_q;

endmodule

// File: rtl/multiphase_driver.sv
// N-channel complementary gate driver: shared period counter, per-channel duty/phase compare,
// shadowed config applied at the period boundary, continuous/burst run control.
module multiphase_driver
  import multiphase_driver_pkg::*;
#(
  parameter int unsigned N_CH       = MDRV_N_CH,
  parameter int unsigned PER_BITS   = MDRV_PER_BITS,
  parameter int unsigned DT_BITS    = MDRV_DT_BITS,
  parameter int unsigned BURST_BITS = MDRV_BURST_BITS
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [PER_BITS-1:0]      cfg_period,
  input  logic [N_CH*PER_BITS-1:0] cfg_duty,
  input  logic [N_CH*PER_BITS-1:0] cfg_phase,
  input  logic [DT_BITS-1:0]       cfg_dead,
  input  logic [BURST_BITS-1:0]    cfg_burst_len,
  input  logic                     cfg_load,
  input  logic                     start,
  input  logic                     burst_mode,
  input  logic                     stop,
  output logic                     busy,
  output logic                     period_tick,
  output logic [N_CH-1:0]          drv_p,
  output logic [N_CH-1:0]          drv_n
);

  mdrv_cfg_t                 cfg_in;
  mdrv_cfg_t                 shadow_q, active_q;
  logic                      pending_q, pending_d;
  state_t                    state_q, state_d;
  logic [PER_BITS-1:0]       cnt_q, cnt_d;
  logic [BURST_BITS-1:0]     remaining_q, remaining_d;
  logic                      running, wrap, apply, dt_enable;
  logic [N_CH-1:0]           raw;
  logic [N_CH-1:0][DT_BITS-1:0] dead_cnt_all;
  logic                      unused_dead_cnt;

  always_comb begin
    cfg_in           = '0;
    cfg_in.period    = cfg_period;
    cfg_in.duty      = cfg_duty;
    cfg_in.phase     = cfg_phase;
    cfg_in.dead      = cfg_dead;
    cfg_in.burst_len = cfg_burst_len;
  end

  assign running = (state_q != StIdle);
  assign wrap    = running && (cnt_q == active_q.period - PER_BITS'(1));
  // pending_q is registered, so a load on a wrap cycle waits for the following wrap.
  assign apply   = pending_q && (!running || wrap);

  always_comb begin
    pending_d = pending_q;
    if (cfg_load) begin
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          if (!burst_mode) begin
            state_d = StRun;
          end else if (active_q.burst_len != '0) begin
            state_d     = StBurst;
            remaining_d = active_q.burst_len;
          end
        end
      end
      StRun: begin
        if (stop) begin
          state_d = wrap ? StIdle : StStopping;
        end
      end
      StBurst: begin
        if (wrap && (remaining_q == BURST_BITS'(1))) begin
          state_d = StIdle;
        end else begin
          if (wrap) begin
            remaining_d = remaining_q - BURST_BITS'(1);
          end
          if (stop) begin
            state_d = wrap ? StIdle : StStopping;
          end
        end
      end
      StStopping: begin
        if (wrap) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cnt_d = (!running || wrap) ? '0 : cnt_q + PER_BITS'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      state_q     <= StIdle;
      cnt_q       <= '0;
      remaining_q <= '0;
    end else begin
      if (cfg_load) begin
        shadow_q <= cfg_in;
      end
      if (apply) begin
        active_q <= sanitize_cfg(shadow_q);
      end
      pending_q   <= pending_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
    end
  end

  // Outputs are enabled only while staying busy, so entering IDLE clears them on the same edge.
  assign dt_enable = running && (state_d != StIdle);

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    logic [PER_BITS-1:0] pos;

    always_comb begin
      if (cnt_q >= active_q.phase[i]) begin
        pos = cnt_q - active_q.phase[i];
      end else begin
        pos = cnt_q + active_q.period - active_q.phase[i];
      end
    end

    assign raw[i] = (pos < active_q.duty[i]);

    drv_deadtime #(
      .DT_BITS(DT_BITS)
    ) u_deadtime (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (raw[i]),
      .dead     (active_q.dead),
      .enable   (dt_enable),
      .p        (drv_p[i]),
      .n        (drv_n[i]),
      .dead_cnt (dead_cnt_all[i])
    );
  end

  assign unused_dead_cnt = ^dead_cnt_all;

  assign busy        = running;
  assign period_tick = wrap;

endmodule

// File: tb/tb_multiphase_driver.sv
// Directed self-checking bench for multiphase_driver.
module tb_multiphase_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] cfg_period;
  logic [63:0] cfg_duty;
  logic [63:0] cfg_phase;
  logic [7:0]  cfg_dead;
  logic [15:0] cfg_burst_len;
  logic        cfg_load;
  logic        start;
  logic        burst_mode;
  logic        stop;
  logic        busy;
  logic        period_tick;
  logic [3:0]  drv_p;
  logic [3:0]  drv_n;

  int checks = 0;
  int errors = 0;

  multiphase_driver #(
    .N_CH      (4),
    .PER_BITS  (16),
    .DT_BITS   (8),
    .BURST_BITS(16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .cfg_phase    (cfg_phase),
    .cfg_dead     (cfg_dead),
    .cfg_burst_len(cfg_burst_len),
    .cfg_load     (cfg_load),
    .start        (start),
    .burst_mode   (burst_mode),
    .stop         (stop),
    .busy         (busy),
    .period_tick  (period_tick),
    .drv_p        (drv_p),
    .drv_n        (drv_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // High and low side must never conduct together.
  always @(negedge clk) check("no_overlap", 32'(drv_p & drv_n), 32'(0));

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_cfg(input logic [15:0] per, input logic [63:0] duty,
                          input logic [63:0] phase, input logic [7:0] dead,
                          input logic [15:0] blen);
    cfg_period    = per;
    cfg_duty      = duty;
    cfg_phase     = phase;
    cfg_dead      = dead;
    cfg_burst_len = blen;
    cfg_load      = 1'b1;
    step(1);
    cfg_load = 1'b0;
    step(3);
  endtask

  task automatic start_run(input logic mode);
    burst_mode = mode;
    start      = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic stop_run();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      step(1);
      n++;
    end
    check(tag, 32'(busy), 32'(0));
  endtask

  initial begin
    int   d;
    int   ticks;
    int   hc1;
    int   hc2;
    int   rise[4];
    logic ep;
    logic en;
    logic et;
    logic seen;
    logic [3:0] prev;

    rst_n = 1'b0; cfg_period = '0; cfg_duty = '0; cfg_phase = '0; cfg_dead = '0;
    cfg_burst_len = '0; cfg_load = 1'b0; start = 1'b0; burst_mode = 1'b0; stop = 1'b0;
    step(2);
    check("reset_outputs", 32'({busy, period_tick, drv_p, drv_n}), 32'(0));
    rst_n = 1'b1;
    step(2);
    check("reset_idle", 32'({busy, period_tick, drv_p, drv_n}), 32'(0));

    // Basic 5/5 waveform, tick every 10, then stop mid-period.
    load_cfg(16'd10, {48'd0, 16'd5}, 64'd0, 8'd0, 16'd0);
    start_run(1'b0);
    check("t1_first", 32'({period_tick, busy, drv_p[0], drv_n[0]}), 32'(4'b0100));
    ticks = 0;
    for (int k = 2; k <= 31; k++) begin
      step(1);
      d  = (k - 2) % 10;
      ep = (d < 5);
      et = ((k - 1) % 10 == 9);
      if (period_tick) ticks++;
      check("t1_wave", 32'({period_tick, busy, drv_p[0], drv_n[0]}), 32'({et, 1'b1, ep, ~ep}));
    end
    check("t1_ticks", 32'(ticks), 32'(3));
    stop = 1'b1;
    for (int k = 32; k <= 40; k++) begin
      step(1);
      stop = 1'b0;
      d  = (k - 2) % 10;
      ep = (d < 5);
      et = ((k - 1) % 10 == 9);
      check("stop_wave", 32'({period_tick, busy, drv_p[0], drv_n[0]}), 32'({et, 1'b1, ep, ~ep}));
    end
    step(1);
    check("stop_idle", 32'({period_tick, busy, drv_p, drv_n}), 32'(0));

    // Phase-shifted channels: rising edges 25 clocks apart.
    load_cfg(16'd100, {4{16'd50}}, {16'd75, 16'd50, 16'd25, 16'd0}, 8'd0, 16'd0);
    start_run(1'b0);
    prev = drv_p;
    for (int i = 0; i < 4; i++) rise[i] = 0;
    for (int k = 2; k <= 200; k++) begin
      step(1);
      for (int i = 0; i < 4; i++) begin
        if (k > 100 && drv_p[i] && !prev[i] && rise[i] == 0) rise[i] = k;
      end
      prev = drv_p;
    end
    check("phase_rise0", 32'(rise[0]), 32'(102));
    check("phase_rise1", 32'(rise[1]), 32'(127));
    check("phase_rise2", 32'(rise[2]), 32'(152));
    check("phase_rise3", 32'(rise[3]), 32'(177));
    stop_run();
    wait_idle("phase_idle", 200);

    // Dead time of 3 clocks after each raw edge.
    load_cfg(16'd20, {48'd0, 16'd10}, 64'd0, 8'd3, 16'd0);
    start_run(1'b0);
    step(20);
    for (int k = 22; k <= 61; k++) begin
      step(1);
      d  = (k - 2) % 20;
      ep = (d >= 3 && d < 10);
      en = (d >= 13);
      check("dead_wave", 32'({drv_p[0], drv_n[0]}), 32'({ep, en}));
    end
    stop_run();
    wait_idle("dead_idle", 50);

    // Config update mid-period applies at the next wrap.
    load_cfg(16'd10, {48'd0, 16'd5}, 64'd0, 8'd0, 16'd0);
    start_run(1'b0);
    step(10);
    hc1 = 0;
    hc2 = 0;
    for (int k = 12; k <= 41; k++) begin
      step(1);
      if (k == 16) cfg_load = 1'b0;
      d  = (k - 2) % 10;
      ep = (k <= 21) ? (d < 5) : (d < 2);
      if (k <= 21 && drv_p[0]) hc1++;
      if (k >= 22 && k <= 31 && drv_p[0]) hc2++;
      check("update_wave", 32'({drv_p[0], drv_n[0]}), 32'({ep, ~ep}));
      if (k == 15) begin
        cfg_duty = {48'd0, 16'd2};
        cfg_load = 1'b1;
      end
    end
    check("update_old_high", 32'(hc1), 32'(5));
    check("update_new_high", 32'(hc2), 32'(2));
    stop_run();
    wait_idle("update_idle", 50);

    // Burst of three periods.
    load_cfg(16'd10, {48'd0, 16'd5}, 64'd0, 8'd0, 16'd3);
    start_run(1'b1);
    ticks = 0;
    for (int n = 0; n < 100 && busy; n++) begin
      if (period_tick) ticks++;
      step(1);
    end
    check("burst_ticks", 32'(ticks), 32'(3));
    check("burst_done", 32'({busy, period_tick, drv_p, drv_n}), 32'(0));

    // Zero-length burst never starts.
    load_cfg(16'd10, {48'd0, 16'd5}, 64'd0, 8'd0, 16'd0);
    start_run(1'b1);
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (busy) seen = 1'b1;
      step(1);
    end
    check("burst_zero", 32'(seen), 32'(0));

    // Start and stop together: stop wins.
    burst_mode = 1'b0;
    start      = 1'b1;
    stop       = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    seen  = busy;
    step(3);
    check("start_stop", 32'({seen, busy}), 32'(0));

    // Period clamped to 2; duty>=period const high; duty 0 const low; phase saturates.
    load_cfg(16'd1, {16'd0, 16'd1, 16'd0, 16'd5}, {16'd0, 16'd7, 16'd0, 16'd0}, 8'd0, 16'd0);
    start_run(1'b0);
    step(1);
    for (int k = 3; k <= 12; k++) begin
      step(1);
      et = ((k - 1) % 2 == 1);
      ep = ((k - 2) % 2 == 1);
      check("min_period", 32'({period_tick, drv_p[2:0]}), 32'({et, ep, 1'b0, 1'b1}));
    end
    stop_run();
    wait_idle("min_idle", 20);

    // Asynchronous reset mid-run.
    load_cfg(16'd10, {48'd0, 16'd5}, 64'd0, 8'd0, 16'd0);
    start_run(1'b0);
    step(4);
    check("pre_reset_high", 32'({busy, drv_p[0]}), 32'(2'b11));
    #1 rst_n = 1'b0;
    #1 check("async_reset", 32'({busy, period_tick, drv_p, drv_n}), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step(2);
    check("post_reset", 32'({busy, period_tick, drv_p, drv_n}), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
